// File: rtl/fp_exponent_align_mul_if.sv
// Operand/result handshake bundle for the exponent unit.
// The slave view belongs to the exponent unit; the master view drives it and takes its results.
interface fp_exponent_align_mul_if #(
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned SHIFT_WIDTH = 5
);
    logic                   valid_in;
    logic                   ready_out;
    logic                   mode_in;
    logic [EXP_WIDTH-1:0]   in_exp_a;
    logic [EXP_WIDTH-1:0]   in_exp_b;
    logic                   valid_out;
    logic                   ready_in;
    logic [EXP_WIDTH-1:0]   out_exp;
    logic [SHIFT_WIDTH-1:0] out_shift;
    logic                   out_swap;
    logic                   out_shift_sat;
    logic                   out_ovf;
    logic                   out_unf;

    modport slave (
        input  valid_in, mode_in, in_exp_a, in_exp_b, ready_in,
        output ready_out, valid_out, out_exp, out_shift, out_swap, out_shift_sat, out_ovf, out_unf
    );

    modport master (
        output valid_in, mode_in, in_exp_a, in_exp_b, ready_in,
        input  ready_out, valid_out, out_exp, out_shift, out_swap, out_shift_sat, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_exponent_align_mul.sv
// Two-stage exponent unit: ADD picks the larger exponent and a saturated alignment shift,
// MUL forms the biased exponent sum with overflow/underflow clamping.
module fp_exponent_align_mul #(
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned BIAS        = 127,
    parameter int unsigned SHIFT_WIDTH = 5,
    parameter int unsigned MAX_SHIFT   = 27
) (
    input logic                    clk,
    input logic                    reset_n,
    fp_exponent_align_mul_if.slave bus
);
    localparam int unsigned RAW_W = EXP_WIDTH + 2;

    typedef logic signed [RAW_W-1:0] raw_t;

    localparam raw_t OVF_LIM  = raw_t'((2 ** EXP_WIDTH) - 1);
    localparam raw_t SAT_LIM  = raw_t'(MAX_SHIFT);
    localparam raw_t BIAS_X   = raw_t'(BIAS);
    localparam raw_t RAW_ZERO = raw_t'(0);

    logic                   rdy_en;
    logic                   s1_valid;
    logic                   s1_mode;
    logic                   s1_swap;
    logic                   s1_zero;
    logic [EXP_WIDTH-1:0]   s1_max;
    raw_t                   s1_raw;

    logic                   s2_valid;
    logic [EXP_WIDTH-1:0]   s2_exp;
    logic [SHIFT_WIDTH-1:0] s2_shift;
    logic                   s2_swap;
    logic                   s2_sat;
    logic                   s2_ovf;
    logic                   s2_unf;

    logic                   out_xfer_c;
    logic                   s1_advance_c;
    logic                   ready_c;
    logic                   in_xfer_c;

    raw_t                   a_x_c;
    raw_t                   b_x_c;
    raw_t                   raw_c;
    logic                   swap_c;
    logic                   zero_c;
    logic [EXP_WIDTH-1:0]   max_c;

    logic [EXP_WIDTH-1:0]   exp_c;
    logic [SHIFT_WIDTH-1:0] shift_c;
    logic                   swap2_c;
    logic                   sat_c;
    logic                   ovf_c;
    logic                   unf_c;

    // Pipeline advance; ready is held low until the first edge after reset release
    assign out_xfer_c   = s2_valid & bus.ready_in;
    assign s1_advance_c = s1_valid & (~s2_valid | out_xfer_c);
    assign ready_c      = rdy_en & (~s1_valid | s1_advance_c);
    assign in_xfer_c    = bus.valid_in & ready_c;

    // Stage 1 operand evaluation on the extended signed range
    always_comb begin
        a_x_c  = raw_t'({2'b00, bus.in_exp_a});
        b_x_c  = raw_t'({2'b00, bus.in_exp_b});
        swap_c = bus.in_exp_b > bus.in_exp_a;
        max_c  = swap_c ? bus.in_exp_b : bus.in_exp_a;
        zero_c = (bus.in_exp_a == '0) || (bus.in_exp_b == '0);
        if (bus.mode_in) begin
            raw_c = a_x_c + b_x_c - BIAS_X;
        end else begin
            raw_c = swap_c ? (b_x_c - a_x_c) : (a_x_c - b_x_c);
        end
    end

    // Stage 2 result formation; MUL checks are ordered zero, overflow, underflow
    always_comb begin
        exp_c   = '0;
        shift_c = '0;
        swap2_c = 1'b0;
        sat_c   = 1'b0;
        ovf_c   = 1'b0;
        unf_c   = 1'b0;
        if (!s1_mode) begin
            exp_c   = s1_max;
            swap2_c = s1_swap;
            if (s1_raw > SAT_LIM) begin
                sat_c   = 1'b1;
                shift_c = SHIFT_WIDTH'(MAX_SHIFT);
            end else begin
                shift_c = s1_raw[SHIFT_WIDTH-1:0];
            end
        end else if (s1_zero) begin
            exp_c = '0;
        end else if (s1_raw >= OVF_LIM) begin
            exp_c = '1;
            ovf_c = 1'b1;
        end else if (s1_raw <= RAW_ZERO) begin
            unf_c = 1'b1;
        end else begin
            exp_c = s1_raw[EXP_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_swap  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_max   <= '0;
            s1_raw   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (in_xfer_c) begin
                s1_valid <= 1'b1;
                s1_mode  <= bus.mode_in;
                s1_swap  <= swap_c;
                s1_zero  <= zero_c;
                s1_max   <= max_c;
                s1_raw   <= raw_c;
            end else if (s1_advance_c) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_exp   <= '0;
            s2_shift <= '0;
            s2_swap  <= 1'b0;
            s2_sat   <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_unf   <= 1'b0;
        end else if (s1_advance_c) begin
            s2_valid <= 1'b1;
            s2_exp   <= exp_c;
            s2_shift <= shift_c;
            s2_swap  <= swap2_c;
            s2_sat   <= sat_c;
            s2_ovf   <= ovf_c;
            s2_unf   <= unf_c;
        end else if (out_xfer_c) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.ready_out     = ready_c;
    assign bus.valid_out     = s2_valid;
    assign bus.out_exp       = s2_exp;
    assign bus.out_shift     = s2_shift;
    assign bus.out_swap      = s2_swap;
    assign bus.out_shift_sat = s2_sat;
    assign bus.out_ovf       = s2_ovf;
    assign bus.out_unf       = s2_unf;

endmodule
